mux4_rr_arbiter: RTL and testbench
==================================

# mux4_rr_arbiter

Round-robin arbiter and sequencer that shares one 4:1 single-bit multiplexer among four requesters. It accepts per-requester requests, grants the shared mux to one owner at a time, and drives the mux select. It also provides the registered mux output, so the downstream sink sees a clean, glitch-free bit. The block sits in front of the 4:1 mux datapath and is its only source of `sel`.

## Interface
- `MAX_HOLD`, default 4: maximum consecutive grant cycles per owner while others wait. Legal range is 1..15. Active only with the hold-limit feature compiled in.
- `clk`, input, 1: single clock, rising edge.
- `rst_n`, input, 1: asynchronous active-low reset.
- `req`, input, 4: request from requester i. It must stay high for as long as the requester wants the mux.
- `a`, input, 4: mux data inputs. Bit i belongs to requester i.
- `grant`, output, 4: one-hot grant, registered. It is all-zero when there is no owner.
- `sel`, output, 2: mux select, registered. It equals the index of the set `grant` bit, and holds its last value when idle.
- `gnt_valid`, output, 1: high while `grant` is non-zero.
- `y`, output, 1: registered mux output.

## Operation
- FSM states:
  - IDLE: no owner. `grant`=0, `gnt_valid`=0.
  - OWN: exactly one `grant` bit is set.
- Round-robin pointer `ptr` (2 bits) holds the highest-priority index for the next arbitration. Search order is ptr, ptr+1, ptr+2, ptr+3 (mod 4). The first set `req` bit wins. On each new grant to index k, `ptr` becomes k+1 mod 4.
- IDLE to OWN: at any edge where `req` is non-zero, grant the round-robin winner.
- OWN, owner's `req` still high:
  - Hold limit not reached: keep the grant.
  - Hold limit reached (hold count = MAX_HOLD-1) and another `req` bit is set: re-arbitrate at that edge. The owner is excluded because `ptr` is already past it.
  - Hold limit reached and no other request: keep the grant and clear the hold count.
- OWN, owner's `req` low:
  - Another `req` bit is set: re-arbitrate at the same edge. The grant moves directly to the new winner with no idle bubble, and the hold count resets to 0.
  - `req`=0: go to IDLE. `sel` holds its last value.
- Hold count is 4 bits. It is 0 on each new grant and increments each cycle the same owner keeps the grant.
- Output `y`: on each edge, `y` <= `gnt_valid` ? `a[sel]` : 0, using the current registered `sel`.
- `grant`, `sel` and `gnt_valid` change only at clock edges and are always mutually consistent.

## Timing
- Reset values: `grant`=4'b0000, `sel`=2'b00, `gnt_valid`=0, `y`=0, `ptr`=0, hold count=0, state IDLE. Reset is asynchronous on assert and takes effect immediately, including mid-grant. Logic leaves reset on the first edge after `rst_n` rises.
- Grant latency: a `req` sampled high at edge n (with the mux free) produces `grant`/`sel`/`gnt_valid` valid after edge n.
- Release latency: owner `req` sampled low at edge n causes the grant to move or clear after edge n.
- `y` lags `sel` by one cycle. Data on `a` in cycle c appears on `y` after edge c+1.
- Simultaneous requests are resolved purely by `ptr`. There is no fixed priority except after reset (0 first).
- When a requester drops `req` at the same edge another raises it, the rising requester is eligible at that edge.

## Configuration
- `MUX4_ARB_HOLD_LIMIT_EN`:
  - Defined: the `MAX_HOLD` burst limit and hold counter are compiled in, and an owner is pre-empted after MAX_HOLD cycles when others wait.
  - Undefined: no counter exists, `MAX_HOLD` is ignored, and an owner keeps the grant until it drops `req`.

## Test plan
- Reset and single request:
  - Stimulus: `rst_n` low, then `req`=4'b0100 with a[2]=1.
  - Response: during reset all outputs are 0. After the first edge, `grant`=0100, `sel`=2, `gnt_valid`=1. One edge later, `y`=1.
- Simultaneous requests from reset:
  - Stimulus: `req`=4'b1111 held with MAX_HOLD=4, hold limit enabled.
  - Response: owners are 0,1,2,3,0, each for 4 cycles, with no idle cycles between them.
- Release without bubble:
  - Stimulus: owner 1 (`req`=0011→0001).
  - Response: the grant moves from 1 to 0 at the edge where req[1] is sampled low. `gnt_valid` stays 1 throughout.
- Lone owner past the limit:
  - Stimulus: only req[3] high for 12 cycles, hold limit enabled.
  - Response: `grant` stays 1000 for the full 12 cycles, with no gap.
- Hold limit compiled out:
  - Stimulus: `req`=4'b0011 for 10 cycles, with `MUX4_ARB_HOLD_LIMIT_EN` undefined.
  - Response: `grant`=0001 for all 10 cycles.
- Mid-grant reset:
  - Stimulus: `rst_n` pulsed low while owner 2 holds the grant.
  - Response: outputs clear immediately. After release, with `req`=1111, the grant goes to index 0.

Source files
------------

// File: rtl/mux4_rr_arbiter.sv
// Round-robin owner arbiter for a shared 4:1 single-bit mux; drives sel and a registered, glitch-free y.
// Optional burst limit per owner is compiled in with `define MUX4_ARB_HOLD_LIMIT_EN (uses MAX_HOLD).
module mux4_rr_arbiter #(
  parameter int MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic [3:0] a,
  output logic [3:0] grant,
  output logic [1:0] sel,
  output logic       gnt_valid,
  output logic       y
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  if (MAX_HOLD < 1 || MAX_HOLD > 15) begin : g_bad_max_hold
    $error("mux4_rr_arbiter: MAX_HOLD must be in 1..15");
  end

  state_t     state_r, state_nxt_s;
  logic [1:0] ptr_r, ptr_nxt_s;
  logic [3:0] grant_nxt_s;
  logic [1:0] sel_nxt_s;
  logic       gv_nxt_s;
  logic [2:0] pick_s;
  logic       take_new_s;
  logic       go_idle_s;

`ifdef MUX4_ARB_HOLD_LIMIT_EN
  localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);
  logic [3:0] hold_r, hold_nxt_s;
`endif

  // First set request bit in the order ptr, ptr+1, ptr+2, ptr+3; returns {found, index}.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [2:0] res;
    logic [1:0] c;
    res = 3'b000;
    c   = 2'b00;
    for (int i = 3; i >= 0; i--) begin
      c = p + 2'(i);
      if (r[c]) begin
        res = {1'b1, c};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // Decide between granting a new winner, going idle, or keeping the current owner.
  always_comb begin
    pick_s     = rr_pick(req, ptr_r);
    take_new_s = 1'b0;
    go_idle_s  = 1'b0;
`ifdef MUX4_ARB_HOLD_LIMIT_EN
    hold_nxt_s = hold_r;
`endif
    case (state_r)
      IDLE: begin
        if (pick_s[2]) begin
          take_new_s = 1'b1;
        end else begin
          go_idle_s = 1'b1;
        end
      end
      OWN: begin
        if (req[sel]) begin
`ifdef MUX4_ARB_HOLD_LIMIT_EN
          // At the limit the owner yields only if someone else is waiting.
          if (hold_r == HOLD_LAST) begin
            if ((req & ~grant) != 4'b0000) begin
              take_new_s = 1'b1;
            end else begin
              hold_nxt_s = 4'd0;
            end
          end else begin
            hold_nxt_s = hold_r + 4'd1;
          end
`else
          take_new_s = 1'b0;
`endif
        end else if (pick_s[2]) begin
          take_new_s = 1'b1;
        end else begin
          go_idle_s = 1'b1;
        end
      end
      default: begin
        go_idle_s = 1'b1;
      end
    endcase
  end

  // Next values for the registered grant/sel/valid and the round-robin pointer.
  always_comb begin
    state_nxt_s = state_r;
    grant_nxt_s = grant;
    sel_nxt_s   = sel;
    gv_nxt_s    = gnt_valid;
    ptr_nxt_s   = ptr_r;
    if (take_new_s) begin
      state_nxt_s = OWN;
      grant_nxt_s = 4'b0001 << pick_s[1:0];
      sel_nxt_s   = pick_s[1:0];
      gv_nxt_s    = 1'b1;
      ptr_nxt_s   = pick_s[1:0] + 2'd1;
    end else if (go_idle_s) begin
      state_nxt_s = IDLE;
      grant_nxt_s = 4'b0000;
      gv_nxt_s    = 1'b0;
    end else begin
      state_nxt_s = state_r;
      grant_nxt_s = grant;
    end
  end

  // State, outputs and pointer; y samples the mux through the already-registered select.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      grant     <= 4'b0000;
      sel       <= 2'b00;
      gnt_valid <= 1'b0;
      ptr_r     <= 2'b00;
      y         <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      grant     <= grant_nxt_s;
      sel       <= sel_nxt_s;
      gnt_valid <= gv_nxt_s;
      ptr_r     <= ptr_nxt_s;
      y         <= gnt_valid ? a[sel] : 1'b0;
    end
  end

`ifdef MUX4_ARB_HOLD_LIMIT_EN
  // Hold counter restarts on every new grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_r <= 4'd0;
    end else if (take_new_s) begin
      hold_r <= 4'd0;
    end else begin
      hold_r <= hold_nxt_s;
    end
  end
`endif

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed self-checking bench for mux4_rr_arbiter; adapts to MUX4_ARB_HOLD_LIMIT_EN.
module tb_mux4_rr_arbiter;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] a;
  logic [3:0] grant;
  logic [1:0] sel;
  logic       gnt_valid;
  logic       y;
  int checks = 0;
  int errors = 0;

  mux4_rr_arbiter #(.MAX_HOLD(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .a(a),
    .grant(grant), .sel(sel), .gnt_valid(gnt_valid), .y(y)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    rst_n = 1'b0; req = 4'b0000; a = 4'b0000;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 4'b0100; a = 4'b0100;
    #3;
    checks++; if ({grant, sel, gnt_valid, y} !== 8'b0) begin errors++; $display("FAIL reset_outputs: got %b expected %b", {grant, sel, gnt_valid, y}, 8'b0); end
    @(posedge clk); #1;
    checks++; if ({grant, sel, gnt_valid, y} !== 8'b0) begin errors++; $display("FAIL reset_held_with_req: got %b expected %b", {grant, sel, gnt_valid, y}, 8'b0); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL single_grant: got %b expected %b", grant, 4'b0100); end
    checks++; if (sel !== 2'd2) begin errors++; $display("FAIL single_sel: got %0d expected %0d", sel, 2); end
    checks++; if (gnt_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b expected %b", gnt_valid, 1'b1); end
    checks++; if (y !== 1'b0) begin errors++; $display("FAIL single_y_lag: got %b expected %b", y, 1'b0); end
    @(posedge clk); #1;
    checks++; if (y !== 1'b1) begin errors++; $display("FAIL single_y: got %b expected %b", y, 1'b1); end
    req = 4'b0000;
    @(posedge clk); #1;
    checks++; if ({grant, gnt_valid} !== 5'b0) begin errors++; $display("FAIL idle_clear: got %b expected %b", {grant, gnt_valid}, 5'b0); end
    checks++; if (sel !== 2'd2) begin errors++; $display("FAIL idle_sel_hold: got %0d expected %0d", sel, 2); end
  endtask

`ifdef MUX4_ARB_HOLD_LIMIT_EN
  task automatic test_rotation();
    logic [3:0] exp_g;
    do_reset();
    req = 4'b1111;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(posedge clk); #1;
      exp_g = 4'b0001 << ((cyc / 4) % 4);
      checks++; if (grant !== exp_g || gnt_valid !== 1'b1) begin errors++; $display("FAIL rotation cyc %0d: got %b/%b expected %b/1", cyc, grant, gnt_valid, exp_g); end
    end
  endtask
`else
  task automatic test_hold_disabled();
    do_reset();
    req = 4'b0011;
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(posedge clk); #1;
      checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL no_hold_limit cyc %0d: got %b expected %b", cyc, grant, 4'b0001); end
    end
  endtask
`endif

  task automatic test_release_no_bubble();
    do_reset();
    req = 4'b0010;
    @(posedge clk); #1;
    checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL release_setup: got %b expected %b", grant, 4'b0010); end
    req = 4'b0011;
    @(posedge clk); #1;
    checks++; if (grant !== 4'b0010 || gnt_valid !== 1'b1) begin errors++; $display("FAIL release_keep: got %b/%b expected %b/1", grant, gnt_valid, 4'b0010); end
    req = 4'b0001;
    @(posedge clk); #1;
    checks++; if (grant !== 4'b0001 || sel !== 2'd0 || gnt_valid !== 1'b1) begin errors++; $display("FAIL release_move: got %b/%0d/%b expected 0001/0/1", grant, sel, gnt_valid); end
  endtask

  task automatic test_lone_owner();
    logic [11:0] pat;
    logic        exp_y;
    pat = 12'b1011_0011_1010;
    do_reset();
    req = 4'b1000;
    for (int i = 0; i < 12; i++) begin
      a = {pat[i], ~pat[i], ~pat[i], ~pat[i]};
      @(posedge clk); #1;
      exp_y = (i == 0) ? 1'b0 : pat[i];
      checks++; if (grant !== 4'b1000 || sel !== 2'd3) begin errors++; $display("FAIL lone_owner cyc %0d: got %b/%0d expected 1000/3", i, grant, sel); end
      checks++; if (y !== exp_y) begin errors++; $display("FAIL lone_y cyc %0d: got %b expected %b", i, y, exp_y); end
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    req = 4'b0100; a = 4'b0100;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (grant !== 4'b0100 || y !== 1'b1) begin errors++; $display("FAIL midreset_setup: got %b/%b expected 0100/1", grant, y); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({grant, sel, gnt_valid, y} !== 8'b0) begin errors++; $display("FAIL midreset_clear: got %b expected %b", {grant, sel, gnt_valid, y}, 8'b0); end
    req = 4'b1111;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (grant !== 4'b0001 || sel !== 2'd0) begin errors++; $display("FAIL midreset_ptr0: got %b/%0d expected 0001/0", grant, sel); end
  endtask

  initial begin
    test_reset();
`ifdef MUX4_ARB_HOLD_LIMIT_EN
    test_rotation();
`else
    test_hold_disabled();
`endif
    test_release_no_bubble();
    test_lone_owner();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
